// File: rtl/core_config_pkg.sv
// Core-wide configuration: datapath widths, ALU command encoding, and the
// types shared by the ALU2 issue controller.
package core_config_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [3:0] {
    c_NONE,
    c_ADD,
    c_SUB,
    c_MUL,
    c_DIV,
    c_DIVU,
    c_REM,
    c_REMU,
    c_SLL,
    c_SRL,
    c_SRA
  } alu_commands_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } alu2_issue_state_t;

  // rd sits in the low bits so the queue can expose it without knowing the layout
  typedef struct packed {
    logic [XLEN-1:0]       arg0;
    logic [XLEN-1:0]       arg1;
    alu_commands_t         cmd;
    logic [REG_ADDR_W-1:0] rd;
  } alu2_op_t;

  localparam int ALU2_OP_W = $bits(alu2_op_t);

endpackage

// File: rtl/alu2_issue_ctrl_if.sv
// Bundle of decode, ALU2, writeback, flush and hazard-query signals around the
// ALU2 issue controller. The controller is the master side.
interface alu2_issue_ctrl_if;
  import core_config_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [XLEN-1:0]       in_arg0;
  logic [XLEN-1:0]       in_arg1;
  alu_commands_t         in_cmd;
  logic [REG_ADDR_W-1:0] in_rd;

  logic [XLEN-1:0]       alu_arg0;
  logic [XLEN-1:0]       alu_arg1;
  alu_commands_t         alu_cmd;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic                  alu_busy;
  logic                  alu_valid;
  logic                  alu_i_error;
  logic                  alu_o_error;
  logic [XLEN-1:0]       alu_res;
  logic [REG_ADDR_W-1:0] alu_o_rd;
  logic                  alu_clear;

  logic                  wb_valid;
  logic                  wb_ready;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic                  wb_error;

  logic                  illegal;
  logic                  flush;
  logic [REG_ADDR_W-1:0] q_rd;
  logic                  q_hit;
  logic                  idle;

  modport master (
    input  in_valid, in_arg0, in_arg1, in_cmd, in_rd,
    input  alu_busy, alu_valid, alu_i_error, alu_o_error, alu_res, alu_o_rd,
    input  wb_ready, flush, q_rd,
    output in_ready, alu_arg0, alu_arg1, alu_cmd, alu_rd, alu_clear,
    output wb_valid, wb_rd, wb_data, wb_error, illegal, q_hit, idle
  );

  modport slave (
    output in_valid, in_arg0, in_arg1, in_cmd, in_rd,
    output alu_busy, alu_valid, alu_i_error, alu_o_error, alu_res, alu_o_rd,
    output wb_ready, flush, q_rd,
    input  in_ready, alu_arg0, alu_arg1, alu_cmd, alu_rd, alu_clear,
    input  wb_valid, wb_rd, wb_data, wb_error, illegal, q_hit, idle
  );

endinterface

// File: rtl/alu2_issue_fifo.sv
// Small in-order circular queue for pending ALU2 operations. Exposes every
// slot's rd field and occupancy so the controller can answer hazard queries.
module alu2_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [RD_W-1:0]  entry_rd [DEPTH],
  output logic [DEPTH-1:0] entry_valid
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush && !full;
  assign do_pop  = pop && !flush && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + (PTR_W+1)'(1);
      else if (!do_push && do_pop) count_reg <= count_reg - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  assign full  = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign dout  = mem[rd_ptr_reg];

  // Slot occupancy: distance from the read pointer (mod DEPTH) below count
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PTR_W-1:0] offset;
      assign offset          = PTR_W'(gi) - rd_ptr_reg;
      assign entry_valid[gi] = ({1'b0, offset} < count_reg);
      assign entry_rd[gi]    = mem[gi][RD_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/alu2_issue_ctrl.sv
// Sequences queued ALU2 operations one at a time through the cmd/busy/valid/clear
// handshake, holds each result for the writeback arbiter, and answers rd hazards.
module alu2_issue_ctrl
  import core_config_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  alu2_issue_ctrl_if.master bus
);

  alu2_issue_state_t     state_reg, state_next;
  alu2_op_t              issue_reg;
  alu2_op_t              head_op;
  logic                  push, pop, clear, wb_load, illegal_pulse;
  logic                  fifo_full, fifo_empty;
  logic [REG_ADDR_W-1:0] entry_rd [DEPTH];
  logic [DEPTH-1:0]      entry_valid;
  logic [DEPTH-1:0]      entry_hit;
  logic                  discard_reg;
  logic                  discard_now;
  logic                  wb_free;
  logic                  wb_valid_reg;
  logic [REG_ADDR_W-1:0] wb_rd_reg;
  logic [XLEN-1:0]       wb_data_reg;
  logic                  wb_error_reg;

  assign push        = bus.in_valid && !fifo_full && !bus.flush;
  assign discard_now = discard_reg || bus.flush;
  assign wb_free     = !wb_valid_reg || bus.wb_ready;

  alu2_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ALU2_OP_W),
    .RD_W  (REG_ADDR_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .pop         (pop),
    .flush       (bus.flush),
    .din         ({bus.in_arg0, bus.in_arg1, bus.in_cmd, bus.in_rd}),
    .dout        (head_op),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entry_rd    (entry_rd),
    .entry_valid (entry_valid)
  );

  always_comb begin
    state_next    = state_reg;
    pop           = 1'b0;
    clear         = 1'b0;
    wb_load       = 1'b0;
    illegal_pulse = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (!fifo_empty && !bus.alu_busy && !bus.flush) begin
          pop        = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.alu_i_error) begin
          illegal_pulse = 1'b1;
          state_next    = S_IDLE;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // A discarded result never needs the writeback slot, so it clears at once
        if (bus.alu_valid && (discard_now || wb_free)) begin
          clear      = 1'b1;
          wb_load    = !discard_now;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      issue_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (pop) issue_reg <= head_op;
    end
  end

  // Discard must not be armed when no clear will follow (rejected command)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard_reg <= 1'b0;
    end else if (clear) begin
      discard_reg <= 1'b0;
    end else if (bus.flush && ((state_reg == S_WAIT) ||
                               (state_reg == S_ISSUE && !bus.alu_i_error))) begin
      discard_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_reg <= 1'b0;
      wb_rd_reg    <= '0;
      wb_data_reg  <= '0;
      wb_error_reg <= 1'b0;
    end else if (bus.flush) begin
      wb_valid_reg <= 1'b0;
    end else if (wb_load) begin
      wb_valid_reg <= 1'b1;
      wb_rd_reg    <= bus.alu_o_rd;
      wb_data_reg  <= bus.alu_res;
      wb_error_reg <= bus.alu_o_error;
    end else if (bus.wb_ready) begin
      wb_valid_reg <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign entry_hit[gi] = entry_valid[gi] && (entry_rd[gi] == bus.q_rd);
    end
  endgenerate

  assign bus.q_hit = (bus.q_rd != '0) &&
                     ((|entry_hit) ||
                      (state_reg != S_IDLE && issue_reg.rd == bus.q_rd) ||
                      (wb_valid_reg && wb_rd_reg == bus.q_rd));

  assign bus.in_ready  = !fifo_full;
  assign bus.idle      = fifo_empty && (state_reg == S_IDLE) && !wb_valid_reg;
  assign bus.alu_cmd   = (state_reg == S_ISSUE) ? issue_reg.cmd : c_NONE;
  assign bus.alu_arg0  = issue_reg.arg0;
  assign bus.alu_arg1  = issue_reg.arg1;
  assign bus.alu_rd    = issue_reg.rd;
  assign bus.alu_clear = clear;
  assign bus.illegal   = illegal_pulse;
  assign bus.wb_valid  = wb_valid_reg;
  assign bus.wb_rd     = wb_rd_reg;
  assign bus.wb_data   = wb_data_reg;
  assign bus.wb_error  = wb_error_reg;

endmodule

// File: tb/tb_alu2_issue_ctrl.sv
// Bench for alu2_issue_ctrl: behavioural ALU2 with per-command latency, and a
// scoreboard of expected writebacks checked whenever the arbiter accepts one.
module tb_alu2_issue_ctrl;
  import core_config_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu2_issue_ctrl_if bus();

  alu2_issue_ctrl #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic                  err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   wb_cnt = 0;
  int   illegal_cnt = 0;
  int   issue_cnt = 0;

  function automatic logic [XLEN:0] calc(alu_commands_t cmd, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    logic            e;
    r = '0;
    e = 1'b0;
    case (cmd)
      c_MUL:  r = a * b;
      c_DIV:  if (b == '0) begin r = '1; e = 1'b1; end else r = $signed(a) / $signed(b);
      c_DIVU: if (b == '0) begin r = '1; e = 1'b1; end else r = a / b;
      c_REM:  if (b == '0) begin r = a;  e = 1'b1; end else r = $signed(a) % $signed(b);
      c_REMU: if (b == '0) begin r = a;  e = 1'b1; end else r = a % b;
      c_SLL:  r = a << b[4:0];
      c_SRL:  r = a >> b[4:0];
      c_SRA:  r = $signed(a) >>> b[4:0];
      default: r = '0;
    endcase
    return {e, r};
  endfunction

  function automatic bit supported(alu_commands_t cmd);
    return cmd inside {c_MUL, c_DIV, c_DIVU, c_REM, c_REMU, c_SLL, c_SRL, c_SRA};
  endfunction

  function automatic int latency(alu_commands_t cmd);
    if (cmd == c_MUL) return 3;
    if (cmd inside {c_SLL, c_SRL, c_SRA}) return 1;
    return 6;
  endfunction

  // Behavioural ALU2: IDLE -> BUSY (latency) -> OUT until cleared
  int              alu_st;
  int              alu_cnt;
  logic [XLEN-1:0] r_res;
  logic [REG_ADDR_W-1:0] r_rd;
  logic            r_err;
  logic            hold_busy = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_st  <= 0;
      alu_cnt <= 0;
      r_res   <= '0;
      r_rd    <= '0;
      r_err   <= 1'b0;
    end else begin
      case (alu_st)
        0: if (bus.alu_cmd != c_NONE && supported(bus.alu_cmd) && !hold_busy) begin
             {r_err, r_res} <= calc(bus.alu_cmd, bus.alu_arg0, bus.alu_arg1);
             r_rd    <= bus.alu_rd;
             alu_cnt <= latency(bus.alu_cmd);
             alu_st  <= 1;
           end
        1: if (alu_cnt <= 1) alu_st <= 2; else alu_cnt <= alu_cnt - 1;
        default: if (bus.alu_clear) alu_st <= 0;
      endcase
    end
  end

  assign bus.alu_busy    = (alu_st != 0) || hold_busy;
  assign bus.alu_valid   = (alu_st == 2);
  assign bus.alu_res     = r_res;
  assign bus.alu_o_rd    = r_rd;
  assign bus.alu_o_error = r_err;
  assign bus.alu_i_error = (bus.alu_cmd != c_NONE) && !supported(bus.alu_cmd);

  // Scoreboard monitor: an accept happens at the next edge when both are high
  always @(negedge clk) begin
    if (rst_n && bus.wb_valid && bus.wb_ready) begin
      exp_t e;
      wb_cnt++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h err=%b, none expected", bus.wb_rd, bus.wb_data, bus.wb_error);
      end else begin
        e = sb.pop_front();
        if (bus.wb_rd !== e.rd || bus.wb_data !== e.data || bus.wb_error !== e.err) begin
          n_fail++;
          $display("FAIL wb_result: got rd=%0d data=%h err=%b, want rd=%0d data=%h err=%b",
                   bus.wb_rd, bus.wb_data, bus.wb_error, e.rd, e.data, e.err);
        end else begin
          $display("wb accept rd=%0d data=%h err=%b", bus.wb_rd, bus.wb_data, bus.wb_error);
        end
      end
    end
    if (rst_n && bus.illegal) illegal_cnt++;
    if (rst_n && bus.alu_cmd != c_NONE) issue_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input alu_commands_t cmd, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [REG_ADDR_W-1:0] rd, input bit expect_wb);
    logic [XLEN:0] r;
    bit ok;
    bus.in_cmd = cmd; bus.in_arg0 = a; bus.in_arg1 = b; bus.in_rd = rd; bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (bus.in_ready) begin ok = 1'b1; break; end
      tick();
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL push_timeout: in_ready=%b want 1 for rd=%0d", bus.in_ready, rd); end
    if (expect_wb) begin
      r = calc(cmd, a, b);
      sb.push_back('{rd: rd, data: r[XLEN-1:0], err: r[XLEN]});
    end
    $display("push cmd=%s a=%h b=%h rd=%0d", cmd.name(), a, b, rd);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (bus.idle) begin ok = 1'b1; break; end
      tick();
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s_idle_timeout: idle=%b want 1", tag, bus.idle); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.q_rd = 5'd5;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", bus.idle); end
    n_checks++; if (bus.alu_cmd !== c_NONE) begin n_fail++; $display("FAIL reset_alu_cmd: got %0d want c_NONE", bus.alu_cmd); end
    n_checks++; if ({bus.alu_arg0, bus.alu_arg1, bus.alu_rd, bus.alu_clear} !== '0) begin
      n_fail++; $display("FAIL reset_alu_outs: got %h/%h/%0d/%b want 0", bus.alu_arg0, bus.alu_arg1, bus.alu_rd, bus.alu_clear); end
    n_checks++; if ({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_error} !== '0) begin
      n_fail++; $display("FAIL reset_wb: got v=%b rd=%0d d=%h e=%b want 0", bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_error); end
    n_checks++; if ({bus.illegal, bus.q_hit} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: got illegal=%b q_hit=%b want 0", bus.illegal, bus.q_hit); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.idle !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset: got idle=%b in_ready=%b want 1/1", bus.idle, bus.in_ready); end
    $display("reset done");
  endtask

  task automatic test_mul();
    bit found;
    bus.wb_ready = 1'b0;
    push_op(c_MUL, 32'd6, 32'd7, 5'd5, 1'b1);
    n_checks++; if (bus.alu_cmd !== c_NONE) begin n_fail++; $display("FAIL mul_pop_cycle: alu_cmd=%0d want c_NONE", bus.alu_cmd); end
    tick();
    n_checks++; if (bus.alu_cmd !== c_MUL || bus.alu_arg0 !== 32'd6 || bus.alu_arg1 !== 32'd7 || bus.alu_rd !== 5'd5) begin
      n_fail++; $display("FAIL mul_issue: cmd=%0d a=%0d b=%0d rd=%0d want MUL 6 7 5", bus.alu_cmd, bus.alu_arg0, bus.alu_arg1, bus.alu_rd); end
    tick();
    n_checks++; if (bus.alu_cmd !== c_NONE) begin n_fail++; $display("FAIL mul_one_cycle: alu_cmd=%0d want c_NONE", bus.alu_cmd); end
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (bus.alu_clear) begin found = 1'b1; break; end
      tick();
    end
    n_checks++; if (!found || bus.alu_valid !== 1'b1) begin
      n_fail++; $display("FAIL mul_clear: clear seen=%b alu_valid=%b want 1/1", found, bus.alu_valid); end
    tick();
    n_checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd5 || bus.wb_data !== 32'd42 || bus.wb_error !== 1'b0) begin
      n_fail++; $display("FAIL mul_wb: v=%b rd=%0d d=%0d e=%b want 1 5 42 0", bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_error); end
    n_checks++; if (bus.idle !== 1'b0) begin n_fail++; $display("FAIL mul_busy_idle: idle=%b want 0", bus.idle); end
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    n_checks++; if (bus.idle !== 1'b1 || bus.wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL mul_done: idle=%b wb_valid=%b want 1/0", bus.idle, bus.wb_valid); end
  endtask

  task automatic test_back_to_back();
    bus.wb_ready = 1'b1;
    hold_busy = 1'b1;
    push_op(c_MUL,  32'd3,        32'd5,  5'd1,  1'b1);
    push_op(c_SLL,  32'd3,        32'd2,  5'd2,  1'b1);
    push_op(c_DIVU, 32'd100,      32'd7,  5'd3,  1'b1);
    push_op(c_SRA,  32'hF000_0000, 32'd8, 5'd4,  1'b1);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: in_ready=%b want 0", bus.in_ready); end
    fork
      push_op(c_REM, 32'hFFFF_FFF9, 32'd3, 5'd12, 1'b1);
      begin
        tick(); tick(); tick();
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_held: in_ready=%b want 0", bus.in_ready); end
        hold_busy = 1'b0;
      end
    join
    wait_idle("b2b");
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_drain: %0d results outstanding want 0", sb.size()); end
  endtask

  task automatic test_div0();
    bit found;
    bus.wb_ready = 1'b0;
    push_op(c_DIVU, 32'd10, 32'd0, 5'd3, 1'b1);
    push_op(c_SLL,  32'd1,  32'd4, 5'd9, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (bus.wb_valid) begin found = 1'b1; break; end
      tick();
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL div0_wb_timeout: wb_valid=%b want 1", bus.wb_valid); end
    for (int k = 0; k < 20; k++) begin
      n_checks++;
      if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd3 || bus.wb_data !== 32'hFFFF_FFFF || bus.wb_error !== 1'b1 || bus.alu_clear !== 1'b0) begin
        n_fail++; $display("FAIL div0_stall c%0d: v=%b rd=%0d d=%h e=%b clr=%b want 1 3 ffffffff 1 0",
                           k, bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_error, bus.alu_clear);
      end
      tick();
    end
    n_checks++; if (bus.alu_valid !== 1'b1) begin n_fail++; $display("FAIL div0_sll_issued: alu_valid=%b want 1", bus.alu_valid); end
    bus.wb_ready = 1'b1;
    #1;
    n_checks++; if (bus.alu_clear !== 1'b1) begin n_fail++; $display("FAIL div0_clear_on_ready: alu_clear=%b want 1", bus.alu_clear); end
    wait_idle("div0");
  endtask

  task automatic test_illegal();
    int wb0;
    bus.wb_ready = 1'b1;
    wb0 = wb_cnt;
    illegal_cnt = 0;
    push_op(c_ADD, 32'd1, 32'd2, 5'd4, 1'b0);
    push_op(c_SRL, 32'h80, 32'd3, 5'd6, 1'b1);
    wait_idle("illegal");
    n_checks++; if (illegal_cnt != 1) begin n_fail++; $display("FAIL illegal_pulses: got %0d want 1", illegal_cnt); end
    n_checks++; if (wb_cnt - wb0 != 1) begin n_fail++; $display("FAIL illegal_wb_count: got %0d want 1", wb_cnt - wb0); end
  endtask

  task automatic test_flush();
    int wb0;
    int iss0;
    bit found;
    bus.wb_ready = 1'b1;
    wb0 = wb_cnt;
    push_op(c_DIV, 32'd100, 32'd7, 5'd8,  1'b0);
    push_op(c_SLL, 32'd1,   32'd1, 5'd10, 1'b0);
    push_op(c_SRL, 32'd8,   32'd1, 5'd11, 1'b0);
    bus.q_rd = 5'd10;
    #1;
    n_checks++; if (bus.q_hit !== 1'b1 || bus.alu_busy !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre: q_hit=%b alu_busy=%b want 1/1", bus.q_hit, bus.alu_busy); end
    iss0 = issue_cnt;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.q_rd = 5'd11;
    #1;
    n_checks++; if (bus.q_hit !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_queue_empty: q_hit=%b in_ready=%b want 0/1", bus.q_hit, bus.in_ready); end
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (bus.alu_clear) begin found = 1'b1; break; end
      tick();
    end
    n_checks++; if (!found || bus.alu_valid !== 1'b1) begin
      n_fail++; $display("FAIL flush_clear: clear seen=%b alu_valid=%b want 1/1", found, bus.alu_valid); end
    tick();
    n_checks++; if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_wb: wb_valid=%b want 0", bus.wb_valid); end
    wait_idle("flush");
    repeat (5) tick();
    n_checks++; if (wb_cnt != wb0 || issue_cnt != iss0 || bus.idle !== 1'b1) begin
      n_fail++; $display("FAIL flush_after: wb=%0d issues=%0d idle=%b want 0 0 1", wb_cnt - wb0, issue_cnt - iss0, bus.idle); end
  endtask

  task automatic test_hazard();
    bit found;
    bus.wb_ready = 1'b0;
    bus.q_rd = 5'd7;
    push_op(c_SRA, 32'h8000_0000, 32'd4, 5'd7, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      n_checks++;
      if (bus.q_hit !== 1'b1) begin n_fail++; $display("FAIL hazard_inflight c%0d: q_hit=%b want 1", k, bus.q_hit); end
      if (bus.wb_valid) begin found = 1'b1; break; end
      tick();
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL hazard_wb_timeout: wb_valid=%b want 1", bus.wb_valid); end
    bus.q_rd = 5'd0;
    #1;
    n_checks++; if (bus.q_hit !== 1'b0) begin n_fail++; $display("FAIL hazard_rd0: q_hit=%b want 0", bus.q_hit); end
    bus.q_rd = 5'd6;
    #1;
    n_checks++; if (bus.q_hit !== 1'b0) begin n_fail++; $display("FAIL hazard_other: q_hit=%b want 0", bus.q_hit); end
    bus.q_rd = 5'd7;
    tick();
    n_checks++; if (bus.q_hit !== 1'b1) begin n_fail++; $display("FAIL hazard_wb_held: q_hit=%b want 1", bus.q_hit); end
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    n_checks++; if (bus.q_hit !== 1'b0) begin n_fail++; $display("FAIL hazard_after_accept: q_hit=%b want 0", bus.q_hit); end
  endtask

  task automatic test_reset_mid();
    int wb0;
    bus.wb_ready = 1'b1;
    push_op(c_MUL, 32'd9, 32'd9, 5'd13, 1'b0);
    tick();
    bus.q_rd = 5'd13;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.idle !== 1'b1 || bus.alu_cmd !== c_NONE || bus.wb_valid !== 1'b0 || bus.q_hit !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset: idle=%b cmd=%0d wb=%b q_hit=%b in_ready=%b want 1 0 0 0 1",
                         bus.idle, bus.alu_cmd, bus.wb_valid, bus.q_hit, bus.in_ready); end
    tick();
    rst_n = 1'b1;
    wb0 = wb_cnt;
    repeat (15) tick();
    n_checks++; if (wb_cnt != wb0 || bus.idle !== 1'b1) begin
      n_fail++; $display("FAIL midreset_after: wb=%0d idle=%b want 0 1", wb_cnt - wb0, bus.idle); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_arg0 = '0; bus.in_arg1 = '0; bus.in_cmd = c_NONE; bus.in_rd = '0;
    bus.wb_ready = 1'b0; bus.flush = 1'b0; bus.q_rd = '0;
    test_reset();
    test_mul();
    test_back_to_back();
    test_div0();
    test_illegal();
    test_flush();
    test_hazard();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL final_scoreboard: %0d outstanding want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu2_issue_ctrl.md
# alu2_issue_ctrl

Issue controller for the multi-cycle ALU2 unit (mul/div/shift). It buffers ALU2 operations from decode in a small in-order queue and sequences them one at a time into ALU2 through its `cmd`/`busy`/`valid`/`clear` handshake. Each result is captured into a writeback register toward the register-file write arbiter. It also answers destination-register hazard queries for decode and supports pipeline flush.

## Interface
Parameters:
- `DEPTH`, 4: queue entries, power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  decode offers an operation.
- `in_ready`  out  1  queue not full (`count < DEPTH`).
- `in_arg0`, `in_arg1`  in  XLEN  operands.
- `in_cmd`  in  alu_commands_t  operation.
- `in_rd`  in  REG_ADDR_W  destination register.
- `alu_arg0`, `alu_arg1`  out  XLEN  to ALU2.
- `alu_cmd`  out  alu_commands_t  to ALU2; c_NONE except in S_ISSUE.
- `alu_rd`  out  REG_ADDR_W  to ALU2 `i_rd`.
- `alu_busy`, `alu_valid`, `alu_i_error`, `alu_o_error`  in  1  from ALU2.
- `alu_res`  in  XLEN  from ALU2.
- `alu_o_rd`  in  REG_ADDR_W  from ALU2.
- `alu_clear`  out  1  releases ALU2 from its OUT state.
- `wb_valid`  out  1  writeback register holds a result.
- `wb_ready`  in  1  arbiter accepts.
- `wb_rd`  out  REG_ADDR_W.
- `wb_data`  out  XLEN.
- `wb_error`  out  1  divide-by-zero flag.
- `illegal`  out  1  one-cycle pulse when ALU2 rejects a command.
- `flush`  in  1  discard all queued and in-flight work.
- `q_rd`  in  REG_ADDR_W  hazard query.
- `q_hit`  out  1  `q_rd` is a destination in queue, issue register, in flight, or in `wb`. Always 0 for `q_rd == 0`.
- `idle`  out  1  queue empty, FSM in S_IDLE, `wb_valid` low.

## Operation
- Queue is a circular FIFO with read/write pointers and a `count` of width `$clog2(DEPTH)+1`. Push when `in_valid && in_ready`. Simultaneous push and pop keeps `count`.
- FSM states:
  - S_IDLE: if `count>0 && !alu_busy && !flush`, pop the head into the issue register and go to S_ISSUE.
  - S_ISSUE: drive the issue register onto `alu_*`.
    - If `alu_i_error`: pulse `illegal`, go to S_IDLE.
    - Otherwise go to S_WAIT.
  - S_WAIT: wait for `alu_valid`.
    - If the writeback register is free or being accepted this cycle (`!wb_valid || wb_ready`): assert `alu_clear` for one cycle, load `wb_*` from `alu_res`/`alu_o_rd`/`alu_o_error`, go to S_IDLE.
    - Otherwise hold (ALU2 holds `valid`).
- `wb_valid` stays asserted until `wb_ready`; the `wb_*` fields are stable while it is asserted.
- Flush:
  - Empties the queue the same cycle and blocks any push that cycle.
  - A flush in S_ISSUE or S_WAIT sets `discard`. The in-flight result is still cleared from ALU2 but not written to `wb`. `discard` is cleared on that clear.
  - Flush also drops an unaccepted `wb_valid`.
- The in-flight operation's `rd` is held in the issue register until its clear.

## Timing
- Reset values:
  - `in_ready`=1, `idle`=1.
  - `alu_cmd`=c_NONE; all other `alu_*` outputs 0.
  - `alu_clear`=0, `wb_valid`=0, `wb_rd`=0, `wb_data`=0, `wb_error`=0, `illegal`=0, `q_hit`=0.
  - FSM=S_IDLE, `count`=0, `discard`=0.
- Cycle timeline for an enqueue in cycle N with an idle ALU2:
  - N+1: pop.
  - N+2: S_ISSUE; ALU2 samples at the end of the cycle.
  - ALU2 `valid` first seen in cycle V.
  - V: `alu_clear`.
  - V+1: `wb_valid`=1.
- The next issue can be in S_ISSUE at V+2, overlapping a pending writeback.
- `q_hit` is combinational from state. `in_ready` is registered-state derived with no combinational path from `in_valid`.
- Reset mid-operation returns every register to its reset value. ALU2 is reset by the same `rst_n`.

## Structure
- `alu_commands_t`, `XLEN` and `REG_ADDR_W` come from `core_config_pkg`.
- Add `alu2_issue_state_t` (S_IDLE, S_ISSUE, S_WAIT) to that package.
- One sub-module: `alu2_issue_fifo`, parameterised by `DEPTH` and `WIDTH`. It exposes its entries' `rd` fields, which `q_hit` compares against.

## Test plan
- Reset, then push MUL 6×7 rd=5 → ALU2 sees c_MUL for exactly one cycle → `wb_valid` with `wb_rd`=5, `wb_data`=42, `wb_error`=0; `idle` returns to 1 after `wb_ready`.
- Push DEPTH+1 ops back-to-back → `in_ready` drops after the 4th push; the 5th is accepted after the first pop; results appear in push order.
- DIVU 10/0 rd=3 with `wb_ready` held 0 for 20 cycles → `wb_error`=1, `wb_data`=0xFFFFFFFF stable. A following SLL 1<<4 is issued but its `alu_clear` is withheld until `wb_ready`.
- Push an unsupported cmd (c_NONE-class) → `illegal` pulses once, no `wb_valid`, and the next queued op still issues.
- Flush during S_WAIT of DIV with 2 entries queued → queue empty, `alu_clear` asserted on `alu_valid`, no `wb_valid`, `idle`=1 afterwards.
- Queue rd=7 → `q_hit`=1 for `q_rd`=7 from push until `wb` is accepted; `q_rd`=0 → `q_hit`=0.
